uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8-bit, LSB-first, 1-stop-bit asynchronous serial receiver.
//
// Finds each start bit on an idle-high line and confirms it at mid-cell.
// Every later bit is sampled at mid-cell using a 16x oversampling tick.
// Each good byte is presented with a one-cycle valid strobe. Bad frames
// produce a one-cycle error strobe instead.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// last data bit and the stop bit (sense chosen by PARITY_ODD).
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   rx          filtered serial line, idle high, synchronous to clk
//   data[7:0]   last correctly received byte, held until the next good frame
//   valid       one-cycle strobe, data is new
//   frame_err   one-cycle strobe, stop bit sampled low
//   parity_err  one-cycle strobe, parity mismatch (0 without parity)
//   busy        high whenever the receiver is not idle
module uart_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      ph_reg, ph_next;
  logic [2:0]      bitn_reg, bitn_next;
  logic [7:0]      shreg_reg, shreg_next;
  logic            perr_reg, perr_next;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            frame_err_reg, frame_err_next;
  logic            parity_err_reg, parity_err_next;
  logic            tick;

`ifndef UART_RX_PARITY_EN
  // Parity sense only matters when the parity stage is built.
  logic unused_par_odd;
  assign unused_par_odd = PAR_ODD;
`endif

  assign tick = (cnt_reg == CNT_MAX);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    ph_next         = ph_reg;
    bitn_next       = bitn_reg;
    shreg_next      = shreg_reg;
    perr_next       = perr_reg;
    data_next       = data_reg;
    valid_next      = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;

    // Free-running divider and phase while a frame is in progress.
    if (state_reg != IDLE) begin
      cnt_next = tick ? '0 : cnt_reg + 1'b1;
      if (tick) ph_next = ph_reg + 4'd1;
    end

    case (state_reg)
      IDLE: begin
        if (!rx) begin
          state_next = START;
          shreg_next = 8'h00;
          perr_next  = 1'b0;
        end
      end
      START: begin
        // Mid start bit: a high line here means a glitch, not a frame.
        if (tick && ph_reg == 4'd7) begin
          if (rx) begin
            state_next = IDLE;
          end else begin
            ph_next    = 4'd0;
            bitn_next  = 3'd0;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (tick && ph_reg == 4'd15) begin
          shreg_next[bitn_reg] = rx;
          bitn_next            = bitn_reg + 3'd1;
          if (bitn_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && ph_reg == 4'd15) begin
          perr_next  = ((^shreg_reg) ^ PAR_ODD) != rx;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && ph_reg == 4'd15) begin
          if (!rx) begin
            // Stay out of IDLE until the line recovers so a break
            // yields a single frame error.
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end else if (perr_reg) begin
            parity_err_next = 1'b1;
            state_next      = IDLE;
          end else begin
            data_next  = shreg_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Counters restart from zero for every frame.
    if (state_next == IDLE) begin
      cnt_next = '0;
      ph_next  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      ph_reg         <= 4'd0;
      bitn_reg       <= 3'd0;
      shreg_reg      <= 8'h00;
      perr_reg       <= 1'b0;
      data_reg       <= 8'h00;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      ph_reg         <= ph_next;
      bitn_reg       <= bitn_next;
      shreg_reg      <= shreg_next;
      perr_reg       <= perr_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
    end
  end

  assign data       = data_reg;
  assign valid      = valid_reg;
  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx at 1.6 MHz / 10 kbaud
// (one bit = 160 clocks). Expected strobes are queued when a frame is
// launched and retired by a monitor when the receiver strobes.
module tb_uart_rx;

  localparam int BIT_CYC = 160;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 1680;
`else
  localparam int LAT = 1520;
`endif
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  uart_rx #(
    .CLK_HZ    (1_600_000),
    .BAUD      (10_000),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] d;
    int         start;
  } exp_t;

  exp_t       sb[$];
  int         valid_cyc[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: retire one scoreboard entry per strobe cycle.
  always @(posedge clk) begin
    #1;
    if (valid || frame_err || parity_err) begin
      int   kind;
      int   lat;
      exp_t e;
      kind = valid ? K_VALID : (frame_err ? K_FERR : K_PERR);
      check("strobe_exclusive", 32'(valid) + 32'(frame_err) + 32'(parity_err), 1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", kind, 99);
      end else begin
        e   = sb.pop_front();
        lat = cyc - e.start;
        $display("strobe kind=%0d data=0x%02h latency=%0d", kind, data, lat);
        check("strobe_kind", kind, e.kind);
        check("data", data, e.d);
        check($sformatf("latency_%0d_in_window", lat),
              32'((lat >= LAT - 2) && (lat <= LAT + 2)), 1);
        if (valid) valid_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic push_exp(input int kind, input logic [7:0] b);
    exp_t e;
    e.kind  = kind;
    e.start = cyc;
    if (kind == K_VALID) last_good = b;
    e.d = last_good;
    sb.push_back(e);
  endtask

  // Start + data (+ correct even parity when built) + given stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_bit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(1'b1);
  endtask
`endif

  initial begin
    repeat (5) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (50) @(negedge clk);

    // Single frame.
    push_exp(K_VALID, 8'h55);
    send_frame(8'h55, 1'b1);
    repeat (200) @(negedge clk);

    // False start: short low pulse.
    rx = 1'b0;
    repeat (30) @(negedge clk);
    check("false_start_busy", busy, 1);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("false_start_idle", busy, 0);
    check("false_start_data", data, last_good);

    // Framing error followed by a held-low break.
    push_exp(K_FERR, 8'hA5);
    send_frame(8'hA5, 1'b0);
    repeat (2000) @(negedge clk);
    check("break_busy", busy, 1);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("break_released_idle", busy, 0);
    repeat (200) @(negedge clk);
    push_exp(K_VALID, 8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (200) @(negedge clk);

    // Back-to-back frames, no idle gap.
    push_exp(K_VALID, 8'hA5);
    send_frame(8'hA5, 1'b1);
    push_exp(K_VALID, 8'h3C);
    send_frame(8'h3C, 1'b1);
    repeat (200) @(negedge clk);
    if (valid_cyc.size() >= 2)
      check("b2b_spacing", valid_cyc[valid_cyc.size()-1] - valid_cyc[valid_cyc.size()-2], BIT_CYC * 10);
    else
      check("b2b_valid_count", valid_cyc.size(), 2);

    // Reset in the middle of data bit 3 of a 0xFF frame.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (BIT_CYC / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", busy, 0);
    repeat (BIT_CYC * 8) @(negedge clk);
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_idle", busy, 0);
    last_good = 8'h00;
    push_exp(K_VALID, 8'h81);
    send_frame(8'h81, 1'b1);
    repeat (200) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    push_exp(K_VALID, 8'h07);
    send_frame_par(8'h07, 1'b1);
    repeat (200) @(negedge clk);
    push_exp(K_PERR, 8'h07);
    send_frame_par(8'h07, 1'b0);
    repeat (200) @(negedge clk);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
